mem_arbiter: RTL and testbench

//  Parametrised N-port arbiter in front of the single memory port. Replaces the fixed

---
 rtl/riscv_mem_pkg.sv | 17 +
 rtl/mem_arbiter_pick.sv | 36 +++
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared memory-path definitions: access width encodings, arbiter FSM states
// and arbitration mode selectors.
package riscv_mem_pkg;

    localparam logic [1:0] MEM_W_BYTE = 2'd0;
    localparam logic [1:0] MEM_W_HALF = 2'd1;
    localparam logic [1:0] MEM_W_WORD = 2'd2;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational priority picker: first requester at or after 'start', wrapping
// around to index 0. With start = 0 this is plain lowest-index-wins.
module arb_pick #(
    parameter int NPORTS = 2,
    parameter int IW     = 1
) (
    input  logic [NPORTS-1:0] req,
    input  logic [IW-1:0]     start,
    output logic [NPORTS-1:0] gnt,
    output logic [IW-1:0]     gnt_idx,
    output logic              any
);

    // First pass scans [start, NPORTS); if nothing is found there, the second
    // pass lands on the lowest request below start, which is the wrapped winner.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            if (!any && req[i] && (i >= int'(start))) begin
                any     = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = IW'(i);
            end
        end
        for (int i = 0; i < NPORTS; i++) begin
            if (!any && req[i]) begin
                any     = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// N-port arbiter in front of the single downstream memory port: one transaction
// in flight, fixed-priority or round-robin selection, fields latched at grant.
module mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int MODE   = ARB_FIXED
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NPORTS-1:0]    up_req,
    input  logic [NPORTS*AW-1:0] up_addr,
    input  logic [NPORTS-1:0]    up_write,
    input  logic [NPORTS*DW-1:0] up_wdata,
    input  logic [NPORTS-1:0]    up_extend,
    input  logic [NPORTS*2-1:0]  up_width,
    output logic [NPORTS-1:0]    up_ack,
    output logic [DW-1:0]        up_rdata,
    output logic                 dn_req,
    output logic [AW-1:0]        dn_addr,
    output logic                 dn_write,
    output logic [DW-1:0]        dn_wdata,
    output logic                 dn_extend,
    output logic [1:0]           dn_width,
    input  logic                 dn_ack,
    input  logic [DW-1:0]        dn_rdata,
    output logic [NPORTS-1:0]    grant
);

    localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    arb_state_t        state_reg;
    logic [NPORTS-1:0] grant_reg;
    logic [IW-1:0]     ptr_reg;
    logic [IW-1:0]     ptr_next;
    logic              dn_req_reg;
    logic [AW-1:0]     addr_reg;
    logic              write_reg;
    logic [DW-1:0]     wdata_reg;
    logic              extend_reg;
    logic [1:0]        width_reg;

    logic [NPORTS-1:0] pick_gnt;
    logic [IW-1:0]     pick_idx;
    logic [IW-1:0]     pick_start;
    logic              pick_any;
    logic              ack_fire;

    logic [AW-1:0]     sel_addr;
    logic              sel_write;
    logic [DW-1:0]     sel_wdata;
    logic              sel_extend;
    logic [1:0]        sel_width;

    assign pick_start = (MODE == ARB_RR) ? ptr_reg : '0;

    arb_pick #(
        .NPORTS (NPORTS),
        .IW     (IW)
    ) u_pick (
        .req     (up_req),
        .start   (pick_start),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    always_comb begin
        sel_addr   = '0;
        sel_write  = 1'b0;
        sel_wdata  = '0;
        sel_extend = 1'b0;
        sel_width  = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (pick_gnt[i]) begin
                sel_addr   = up_addr[i*AW +: AW];
                sel_write  = up_write[i];
                sel_wdata  = up_wdata[i*DW +: DW];
                sel_extend = up_extend[i];
                sel_width  = up_width[i*2 +: 2];
            end
        end
    end

    // Round-robin pointer holds the index where the next search begins.
    assign ptr_next = (int'(pick_idx) == NPORTS - 1) ? '0 : pick_idx + IW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ARB_IDLE;
            grant_reg  <= '0;
            ptr_reg    <= '0;
            dn_req_reg <= 1'b0;
            addr_reg   <= '0;
            write_reg  <= 1'b0;
            wdata_reg  <= '0;
            extend_reg <= 1'b0;
            width_reg  <= '0;
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    if (pick_any) begin
                        state_reg  <= ARB_BUSY;
                        grant_reg  <= pick_gnt;
                        dn_req_reg <= 1'b1;
                        addr_reg   <= sel_addr;
                        write_reg  <= sel_write;
                        wdata_reg  <= sel_wdata;
                        extend_reg <= sel_extend;
                        width_reg  <= sel_width;
                        if (MODE == ARB_RR) begin
                            ptr_reg <= ptr_next;
                        end
                    end
                end
                ARB_BUSY: begin
                    if (dn_ack) begin
                        state_reg  <= ARB_IDLE;
                        grant_reg  <= '0;
                        dn_req_reg <= 1'b0;
                    end
                end
                default: state_reg <= ARB_IDLE;
            endcase
        end
    end

    // A requester that withdrew while busy gets no ack; the access still completes.
    assign ack_fire = (state_reg == ARB_BUSY) && dn_ack && !reset;

    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_ack
        assign up_ack[gi] = ack_fire & grant_reg[gi] & up_req[gi];
    end

    assign up_rdata  = (|up_ack) ? dn_rdata : '0;
    assign dn_req    = dn_req_reg;
    assign dn_addr   = addr_reg;
    assign dn_write  = write_reg;
    assign dn_wdata  = wdata_reg;
    assign dn_extend = extend_reg;
    assign dn_width  = width_reg;
    assign grant     = grant_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench: a fixed-priority and a round-robin arbiter run
// side by side, each with its own requesters, downstream responder and monitor.
module tb_mem_arbiter;

    localparam int NP   = 3;
    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int NCYC = 3000;

    typedef struct {
        int            due;
        logic [NP-1:0] gnt;
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wd;
        logic          ext;
        logic [1:0]    wid;
    } gexp_t;

    typedef struct {
        int            due;
        logic [NP-1:0] ack;
        logic [DW-1:0] rd;
    } aexp_t;

    logic clk;
    int   checks;
    int   errors;
    int   fin_cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %0h, expected %0h", tag, name, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        logic             reset;
        logic [NP-1:0]    up_req;
        logic [NP*AW-1:0] up_addr;
        logic [NP-1:0]    up_write;
        logic [NP*DW-1:0] up_wdata;
        logic [NP-1:0]    up_extend;
        logic [NP*2-1:0]  up_width;
        logic [NP-1:0]    up_ack;
        logic [DW-1:0]    up_rdata;
        logic             dn_req;
        logic [AW-1:0]    dn_addr;
        logic             dn_write;
        logic [DW-1:0]    dn_wdata;
        logic             dn_extend;
        logic [1:0]       dn_width;
        logic             dn_ack;
        logic [DW-1:0]    dn_rdata;
        logic [NP-1:0]    grant;

        gexp_t gq[$];
        aexp_t aq[$];
        int    cyc;
        bit    done;

        mem_arbiter #(
            .NPORTS (NP),
            .AW     (AW),
            .DW     (DW),
            .MODE   (gi)
        ) dut (
            .clk       (clk),
            .reset     (reset),
            .up_req    (up_req),
            .up_addr   (up_addr),
            .up_write  (up_write),
            .up_wdata  (up_wdata),
            .up_extend (up_extend),
            .up_width  (up_width),
            .up_ack    (up_ack),
            .up_rdata  (up_rdata),
            .dn_req    (dn_req),
            .dn_addr   (dn_addr),
            .dn_write  (dn_write),
            .dn_wdata  (dn_wdata),
            .dn_extend (dn_extend),
            .dn_width  (dn_width),
            .dn_ack    (dn_ack),
            .dn_rdata  (dn_rdata),
            .grant     (grant)
        );

        // Requesters, downstream responder and reference model, all at negedge.
        initial begin : drive
            bit            busy;
            int            owner;
            int            ptr;
            int            wait_cnt;
            int            delay;
            int            w;
            int            p;
            logic [NP-1:0] clr;
            logic [NP-1:0] oh;
            reset = 1'b1;
            up_req = '0; up_addr = '0; up_write = '0; up_wdata = '0;
            up_extend = '0; up_width = '0; dn_ack = 1'b0; dn_rdata = '0;
            cyc = 0; done = 1'b0;
            busy = 1'b0; owner = 0; ptr = 0; wait_cnt = 0; delay = 0; clr = '0;
            for (int c = 0; c < NCYC + 12; c++) begin
                @(negedge clk);
                cyc = c;
                reset = (c < 3) || (busy && ($urandom_range(0, 79) == 0));
                up_req = up_req & ~clr;
                clr = '0;
                for (int i = 0; i < NP; i++) begin
                    if (c >= NCYC) begin
                        up_req[i] = 1'b0;
                    end else if (!up_req[i]) begin
                        if ($urandom_range(0, 2) == 0) begin
                            up_req[i]             = 1'b1;
                            up_addr[i*AW +: AW]   = AW'($urandom);
                            up_write[i]           = 1'($urandom_range(0, 1));
                            up_wdata[i*DW +: DW]  = DW'($urandom);
                            up_extend[i]          = 1'($urandom_range(0, 1));
                            up_width[i*2 +: 2]    = 2'($urandom_range(0, 2));
                        end
                    end else if ($urandom_range(0, 24) == 0) begin
                        up_req[i] = 1'b0;
                    end
                end
                dn_rdata = DW'($urandom);
                if (busy) begin
                    wait_cnt++;
                    dn_ack = (wait_cnt > delay);
                end else begin
                    dn_ack = ($urandom_range(0, 7) == 0);
                end
                // Reference model of what the coming clock edge must do.
                if (reset) begin
                    busy = 1'b0;
                    ptr  = 0;
                end else if (busy) begin
                    if (dn_ack) begin
                        if (up_req[owner]) begin
                            oh = '0;
                            oh[owner] = 1'b1;
                            aq.push_back('{due: c, ack: oh, rd: dn_rdata});
                            clr[owner] = 1'b1;
                        end
                        busy = 1'b0;
                    end
                end else if (up_req != '0) begin
                    w = -1;
                    for (int k = 0; k < NP; k++) begin
                        p = (gi == 1) ? (ptr + k) % NP : k;
                        if (w < 0 && up_req[p]) w = p;
                    end
                    owner = w;
                    ptr = (w + 1) % NP;
                    busy = 1'b1;
                    wait_cnt = 0;
                    delay = $urandom_range(0, 3);
                    oh = '0;
                    oh[w] = 1'b1;
                    gq.push_back('{due: c + 1, gnt: oh, addr: up_addr[w*AW +: AW],
                                   wr: up_write[w], wd: up_wdata[w*DW +: DW],
                                   ext: up_extend[w], wid: up_width[w*2 +: 2]});
                end
            end
            done = 1'b1;
        end

        initial begin : mon
            gexp_t cur;
            gexp_t e;
            aexp_t a;
            bit    last_rst;
            bit    prev_dn_req;
            string tag;
            tag = (gi == 1) ? "rr" : "fixed";
            last_rst = 1'b1;
            prev_dn_req = 1'b0;
            cur = '{due: 0, gnt: '0, addr: '0, wr: 1'b0, wd: '0, ext: 1'b0, wid: '0};
            forever begin
                @(negedge clk);
                #2;
                if (done) break;
                if (last_rst) begin
                    chk(tag, "rst_dn_req", 64'(dn_req), 64'(0));
                    chk(tag, "rst_grant", 64'(grant), 64'(0));
                    chk(tag, "rst_dn_addr", 64'(dn_addr), 64'(0));
                    chk(tag, "rst_dn_write", 64'(dn_write), 64'(0));
                    chk(tag, "rst_dn_wdata", 64'(dn_wdata), 64'(0));
                    chk(tag, "rst_dn_ext", 64'(dn_extend), 64'(0));
                    chk(tag, "rst_dn_width", 64'(dn_width), 64'(0));
                end else if (gq.size() > 0 && gq[0].due == cyc) begin
                    e = gq.pop_front();
                    cur = e;
                    $display("%s cyc %0d grant %b addr %h wr %0d", tag, cyc, e.gnt, e.addr, e.wr);
                    chk(tag, "grant_dn_req", 64'(dn_req), 64'(1));
                    chk(tag, "grant_onehot", 64'(grant), 64'(e.gnt));
                    chk(tag, "grant_addr", 64'(dn_addr), 64'(e.addr));
                    chk(tag, "grant_write", 64'(dn_write), 64'(e.wr));
                    chk(tag, "grant_wdata", 64'(dn_wdata), 64'(e.wd));
                    chk(tag, "grant_ext", 64'(dn_extend), 64'(e.ext));
                    chk(tag, "grant_width", 64'(dn_width), 64'(e.wid));
                end else if (dn_req) begin
                    chk(tag, "unexpected_dn_req_rise", 64'(prev_dn_req), 64'(1));
                    chk(tag, "busy_grant", 64'(grant), 64'(cur.gnt));
                    chk(tag, "busy_addr", 64'(dn_addr), 64'(cur.addr));
                    chk(tag, "busy_write", 64'(dn_write), 64'(cur.wr));
                    chk(tag, "busy_wdata", 64'(dn_wdata), 64'(cur.wd));
                end else begin
                    chk(tag, "idle_grant", 64'(grant), 64'(0));
                end
                if (aq.size() > 0 && aq[0].due == cyc) begin
                    a = aq.pop_front();
                    $display("%s cyc %0d ack %b rdata %h", tag, cyc, a.ack, a.rd);
                    chk(tag, "up_ack", 64'(up_ack), 64'(a.ack));
                    chk(tag, "up_rdata", 64'(up_rdata), 64'(a.rd));
                end else begin
                    chk(tag, "no_up_ack", 64'(up_ack), 64'(0));
                    chk(tag, "idle_up_rdata", 64'(up_rdata), 64'(0));
                end
                last_rst = reset;
                prev_dn_req = dn_req;
            end
            chk(tag, "grants_left", 64'(gq.size()), 64'(0));
            chk(tag, "acks_left", 64'(aq.size()), 64'(0));
            fin_cnt++;
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        fin_cnt = 0;
        for (int t = 0; t < NCYC + 2000 && fin_cnt < 2; t++) @(posedge clk);
        checks++;
        if (fin_cnt < 2) begin
            errors++;
            $display("FAIL timeout: monitors finished %0d, expected 2", fin_cnt);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
